// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a length-prefixed,
// XOR-checksummed frame, writes them into instruction memory and gates the core reset.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst,
  output logic              o_load_done,
  output logic              o_load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [15:0]         r_len;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [31:0]         r_asm;
  logic [7:0]          r_xor;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_core_rst;
  logic                r_load_done;
  logic                r_load_err;

  logic                w_accept;
  logic                w_start;
  logic                w_word_end;
  logic                w_last_word;
  logic [15:0]         w_len_full;
  logic [31:0]         w_word;

  assign o_byte_ready = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept     = o_byte_ready && i_byte_valid;
  assign w_start      = i_load_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_word_end   = (r_state == S_DATA) && w_accept && (r_byte_idx == 2'd3);
  assign w_last_word  = (16'(r_word_idx) == (r_len - 16'd1));
  assign w_len_full   = {i_byte_data, r_len[7:0]};
  // Bytes enter at the top and shift down, so the first byte ends up in [7:0].
  assign w_word       = {i_byte_data, r_asm[31:8]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_LEN0;
      S_LEN0: if (w_accept) w_next = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          if (w_len_full > 16'(DEPTH)) begin
            w_next = S_ERR;
          end else if (w_len_full == 16'd0) begin
            w_next = S_CSUM;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: if (w_word_end && w_last_word) w_next = S_CSUM;
      S_CSUM: if (w_accept) w_next = (i_byte_data == r_xor) ? S_DONE : S_ERR;
      S_DONE: if (w_start) w_next = S_LEN0;
      S_ERR:  if (w_start) w_next = S_LEN0;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len      <= '0;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_asm      <= '0;
      r_xor      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_len      <= '0;
        r_byte_idx <= '0;
        r_word_idx <= '0;
        r_asm      <= '0;
        r_xor      <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= i_byte_data;
          S_LEN1: r_len[15:8] <= i_byte_data;
          S_DATA: begin
            r_xor      <= r_xor ^ i_byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_asm      <= w_word;
            if (r_byte_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_addr     <= r_word_idx;
              r_wdata    <= w_word;
              r_word_idx <= w_last_word ? '0 : r_word_idx + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Status flags are registered from the next state so they change together with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_core_rst  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_core_rst  <= (w_next != S_DONE);
      r_load_done <= (w_next == S_DONE);
      r_load_err  <= (w_next == S_ERR);
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_core_rst   = r_core_rst;
  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;

endmodule
